// File: rtl/sram_async_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_async_ctrl
//  Purpose  : Runs each 32-bit request from the Wishbone slave stage as two
//             16-bit cycles on an external asynchronous SRAM, low halfword
//             first. It returns read data on s_rdata and gives a one-cycle
//             sram_wr_finish pulse when any transaction completes.
//  Ports    : CLK_I, RST_I (async, active-low)
//             s_access/s_we/s_addr/s_wdata : request from the slave stage
//             s_rdata, sram_wr_finish      : result back to the slave stage
//             sram_addr, sram_dq, sram_*_n : asynchronous SRAM pins
//  Revision : 1.0 - initial release
// ============================================================================
module sram_async_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 2
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              s_access,
    input  logic              s_we,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_wdata,
    output logic [31:0]       s_rdata,
    output logic              sram_wr_finish,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    localparam int                CNT_W       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  C_WAIT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_half;
    logic [CNT_W-1:0] r_wait;
    logic             r_armed;
    logic             r_we;
    logic [31:0]      r_wdata;
    logic [15:0]      r_dq_out;
    logic             r_dq_oe;

    // Byte-offset bits and bits above the SRAM address range are unused.
    logic w_unused;
    assign w_unused = ^{s_addr[31:ADDR_W+1], s_addr[1:0]};

    assign sram_dq = r_dq_oe ? r_dq_out : 16'bz;

    // Every pin is registered: each branch loads the pin values that belong
    // to the state being entered, so pins change exactly with the state.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state        <= S_IDLE;
            r_half         <= 1'b0;
            r_wait         <= '0;
            r_armed        <= 1'b0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_dq_out       <= '0;
            r_dq_oe        <= 1'b0;
            s_rdata        <= '0;
            sram_wr_finish <= 1'b0;
            sram_addr      <= '0;
            sram_ce_n      <= 1'b1;
            sram_oe_n      <= 1'b1;
            sram_we_n      <= 1'b1;
            sram_lb_n      <= 1'b1;
            sram_ub_n      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A request level held across completion must not start
                    // a second transaction; a low cycle is needed to re-arm.
                    if (!s_access) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed <= 1'b0;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_we      <= s_we;
                    r_wdata   <= s_wdata;
                    r_half    <= 1'b0;
                    sram_addr <= {s_addr[ADDR_W:2], 1'b0};
                    sram_ce_n <= 1'b0;
                    sram_lb_n <= 1'b0;
                    sram_ub_n <= 1'b0;
                    if (s_we) begin
                        r_dq_oe  <= 1'b1;
                        r_dq_out <= s_wdata[15:0];
                    end else begin
                        sram_oe_n <= 1'b0;
                    end
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_wait <= '0;
                    if (r_we) begin
                        sram_we_n <= 1'b0;
                    end
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_wait == C_WAIT_LAST) begin
                        if (!r_we) begin
                            if (r_half) begin
                                s_rdata[31:16] <= sram_dq;
                            end else begin
                                s_rdata[15:0]  <= sram_dq;
                            end
                        end
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!r_half) begin
                        r_half       <= 1'b1;
                        sram_addr[0] <= 1'b1;
                        if (r_we) begin
                            r_dq_out <= r_wdata[31:16];
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                        r_state <= S_SETUP;
                    end else begin
                        sram_ce_n      <= 1'b1;
                        sram_lb_n      <= 1'b1;
                        sram_ub_n      <= 1'b1;
                        r_dq_oe        <= 1'b0;
                        sram_wr_finish <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    sram_wr_finish <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_async_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_async_ctrl
//  Purpose  : Directed self-checking bench for sram_async_ctrl with a
//             behavioural asynchronous SRAM. A second instance with
//             WAIT_CYC=1 is driven by a fixed-pattern SRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_async_ctrl;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;

    // Main instance, WAIT_CYC=2
    logic        s_access = 1'b0;
    logic        s_we     = 1'b0;
    logic [31:0] s_addr   = '0;
    logic [31:0] s_wdata  = '0;
    logic [31:0] s_rdata;
    logic        sram_wr_finish;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    // Second instance, WAIT_CYC=1
    logic        s1_access = 1'b0;
    logic [31:0] s1_addr   = 32'h0000_0020;
    logic [31:0] s1_rdata;
    logic        s1_fin;
    logic [17:0] c1_addr;
    wire  [15:0] c1_dq;
    logic        c1_ce_n, c1_oe_n, c1_we_n, c1_lb_n, c1_ub_n;

    always #5 CLK_I = ~CLK_I;

    sram_async_ctrl #(.ADDR_W(18), .WAIT_CYC(2)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .s_access(s_access), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .sram_wr_finish(sram_wr_finish),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    sram_async_ctrl #(.ADDR_W(18), .WAIT_CYC(1)) dut1 (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .s_access(s1_access), .s_we(1'b0), .s_addr(s1_addr), .s_wdata(32'h0),
        .s_rdata(s1_rdata), .sram_wr_finish(s1_fin),
        .sram_addr(c1_addr), .sram_dq(c1_dq),
        .sram_ce_n(c1_ce_n), .sram_oe_n(c1_oe_n), .sram_we_n(c1_we_n),
        .sram_lb_n(c1_lb_n), .sram_ub_n(c1_ub_n)
    );

    // Behavioural SRAM for the main instance
    logic [15:0] mem [0:262143];
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'bz;
    always @(posedge CLK_I) begin
        if (RST_I && !sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;
    end

    // Fixed-pattern SRAM for the second instance
    assign c1_dq = (!c1_ce_n && !c1_oe_n) ? (c1_addr[0] ? 16'hABCD : 16'h1234) : 16'bz;

    // Bus protocol monitor
    int viol = 0;
    always @(negedge CLK_I) begin
        if (RST_I) begin
            if (!sram_we_n && !sram_oe_n) viol <= viol + 1;
            if (!sram_ce_n && (sram_lb_n || sram_ub_n)) viol <= viol + 1;
            if (!sram_ce_n && !sram_oe_n && sram_dq != mem[sram_addr]) viol <= viol + 1;
            if (!c1_we_n && !c1_oe_n) viol <= viol + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Observations recorded during a transaction
    logic [17:0] obs_addr [0:3];
    logic [15:0] obs_dq   [0:1];
    int          we_cnt   [0:1];
    int          nh;

    // Runs one transaction starting just after a clock edge with the
    // controller armed; fin is the cycle number of the finish pulse.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int fin);
        fin = -1;
        nh  = 0;
        we_cnt[0] = 0;
        we_cnt[1] = 0;
        obs_dq[0] = '0;
        obs_dq[1] = '0;
        for (int i = 0; i < 4; i++) obs_addr[i] = '0;
        s_access = 1'b1;
        s_we     = we;
        s_addr   = addr;
        s_wdata  = wdata;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK_I); #1;
            if (!sram_ce_n && nh < 4 && (nh == 0 || obs_addr[nh-1] != sram_addr)) begin
                obs_addr[nh] = sram_addr;
                nh++;
            end
            if (!sram_we_n) begin
                obs_dq[sram_addr[0]] = sram_dq;
                we_cnt[sram_addr[0]]++;
            end
            if (sram_wr_finish) begin
                fin = k + 1;
                break;
            end
        end
        s_access = 1'b0;
        @(posedge CLK_I); #1;
        @(posedge CLK_I); #1;
    endtask

    logic [31:0] ref_word [0:15];
    int          fin;
    int          pulses;

    initial begin
        for (int i = 0; i < 16; i++) ref_word[i] = '0;

        // ---- reset state ----
        repeat (2) @(posedge CLK_I);
        #1;
        chk("rst_ctrl", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        chk("rst_rdata", s_rdata, 32'h0);
        chk("rst_fin", {31'd0, sram_wr_finish}, 32'h0);
        chk("rst_addr", {14'd0, sram_addr}, 32'h0);
        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;

        // ---- WAIT_CYC=1 read returning 0x1234 / 0xABCD ----
        s1_access = 1'b1;
        fin = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK_I); #1;
            if (s1_fin) begin
                fin = k + 1;
                break;
            end
        end
        s1_access = 1'b0;
        chk("w1_rdata", s1_rdata, 32'hABCD_1234);
        chk("w1_done_cyc", fin, 32'd8);
        repeat (2) @(posedge CLK_I);
        #1;

        // ---- write 0xDEADBEEF to 0x10 ----
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, fin);
        ref_word[4] = 32'hDEAD_BEEF;
        chk("wr_addr0", {14'd0, obs_addr[0]}, 32'h008);
        chk("wr_addr1", {14'd0, obs_addr[1]}, 32'h009);
        chk("wr_dq0", {16'd0, obs_dq[0]}, 32'hBEEF);
        chk("wr_dq1", {16'd0, obs_dq[1]}, 32'hDEAD);
        chk("wr_we_cnt0", we_cnt[0], 32'd2);
        chk("wr_we_cnt1", we_cnt[1], 32'd2);
        chk("wr_done_cyc", fin, 32'd10);
        chk("wr_keeps_rdata", s_rdata, 32'h0);

        // ---- read it back ----
        run_txn(1'b0, 32'h0000_0010, 32'h0, fin);
        chk("rd_rdata", s_rdata, 32'hDEAD_BEEF);
        chk("rd_done_cyc", fin, 32'd10);

        // ---- level-held request: exactly one transaction ----
        pulses   = 0;
        s_access = 1'b1;
        s_we     = 1'b0;
        s_addr   = 32'h0000_0010;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK_I); #1;
            if (sram_wr_finish) pulses++;
        end
        s_access = 1'b0;
        @(posedge CLK_I); #1;
        @(posedge CLK_I); #1;
        chk("held_pulses", pulses, 32'd1);
        chk("held_rdata", s_rdata, 32'hDEAD_BEEF);

        // ---- top-of-range address ----
        run_txn(1'b1, 32'hFFFF_FFFF, 32'h1357_2468, fin);
        chk("top_addr0", {14'd0, obs_addr[0]}, 32'h3FFFE);
        chk("top_addr1", {14'd0, obs_addr[1]}, 32'h3FFFF);

        // ---- reset during STROBE of write half 1 ----
        s_access = 1'b1;
        s_we     = 1'b1;
        s_addr   = 32'h0000_0040;
        s_wdata  = 32'h5555_AAAA;
        pulses   = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge CLK_I); #1;
            if (sram_wr_finish) pulses++;
        end
        #2;
        RST_I = 1'b0;
        #1;
        chk("abort_ctrl", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge CLK_I); #1;
            if (sram_wr_finish) pulses++;
        end
        chk("abort_no_pulse", pulses, 32'd0);
        s_access = 1'b0;
        @(posedge CLK_I); #1;
        run_txn(1'b1, 32'h0000_0040, 32'h0F0F_F0F0, fin);
        chk("abort_fresh_cyc", fin, 32'd10);

        // ---- sweep writes then random reads/writes ----
        for (int i = 0; i < 100; i++) begin
            logic        we;
            int          idx;
            logic [31:0] a;
            logic [31:0] d;
            if (i < 16) begin
                we  = 1'b1;
                idx = i;
            end else begin
                we  = 1'($urandom_range(0, 1));
                idx = $urandom_range(0, 15);
            end
            a = ($urandom() & 32'hFFF8_0000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            d = $urandom();
            run_txn(we, a, d, fin);
            if (we) begin
                ref_word[idx] = d;
            end else begin
                chk("rand_rdata", s_rdata, ref_word[idx]);
            end
            chk("rand_done_cyc", fin, 32'd10);
        end

        chk("bus_protocol", viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
